// File: rtl/snake_pkg.sv
// Shared grid geometry, cell/direction codes and FSM encoding for the snake playfield engine.
// Helpers here are pure functions used by both the move logic and the pixel query path.
package snake_pkg;

  localparam int GRID_W     = 40;
  localparam int GRID_H     = 30;
  localparam int CELL_SHIFT = 4;
  localparam int X_PIXELS   = GRID_W << CELL_SHIFT;
  localparam int Y_PIXELS   = GRID_H << CELL_SHIFT;

  typedef enum logic [1:0] {
    CELL_NONE = 2'b00,
    CELL_HEAD = 2'b01,
    CELL_BODY = 2'b10,
    CELL_WALL = 2'b11
  } cell_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    ST_PLAY  = 2'b00,
    ST_CHECK = 2'b01,
    ST_MOVE  = 2'b10,
    ST_OVER  = 2'b11
  } state_t;

  // Opposite directions share the axis bit and differ in the sign bit.
  function automatic logic is_reverse(input dir_t a, input dir_t b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

  function automatic logic on_border(input logic [5:0] col, input logic [4:0] row);
    return (col == 6'd0) || (col >= 6'(GRID_W - 1)) ||
           (row == 5'd0) || (row >= 5'(GRID_H - 1));
  endfunction

endpackage

// File: rtl/snake_playfield_engine_if.sv
// Control, apple, pixel-query and status signals between the game/display side and the engine.
// master drives moves and queries; slave is the engine.
interface snake_playfield_engine_if;

  logic       step;
  logic [1:0] dir_in;
  logic [5:0] apple_x;
  logic [4:0] apple_y;
  logic [9:0] x_pos;
  logic [9:0] y_pos;
  logic [1:0] snake;
  logic [5:0] head_x;
  logic [4:0] head_y;
  logic [5:0] length;
  logic       apple_eaten;
  logic       game_over;

  modport master (
    output step, dir_in, apple_x, apple_y, x_pos, y_pos,
    input  snake, head_x, head_y, length, apple_eaten, game_over
  );

  modport slave (
    input  step, dir_in, apple_x, apple_y, x_pos, y_pos,
    output snake, head_x, head_y, length, apple_eaten, game_over
  );

endinterface

// File: rtl/snake_cell_match.sv
// Parallel compare of one grid cell against the first count entries of the segment list.
// Purely combinational; index 0 is reported as head, the rest as body.
module snake_cell_match #(
  parameter int MAX_LEN = 16
) (
  input  logic [5:0] col,
  input  logic [4:0] row,
  input  logic [5:0] seg_x [MAX_LEN],
  input  logic [4:0] seg_y [MAX_LEN],
  input  logic [5:0] count,
  output logic       head_hit,
  output logic       body_hit
);

  always_comb begin
    head_hit = (count != 6'd0) && (seg_x[0] == col) && (seg_y[0] == row);
    body_hit = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((6'(i) < count) && (seg_x[i] == col) && (seg_y[i] == row)) begin
        body_hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/snake_playfield_engine.sv
// Snake game state on a 40x30 grid: step -> CHECK -> MOVE commit (results visible 3 cycles after step),
// plus a registered 1-cycle pixel query returning NONE/HEAD/BODY/WALL.
module snake_playfield_engine
  import snake_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int START_X = 20,
  parameter int START_Y = 15
) (
  input logic                   clk,
  input logic                   reset,
  snake_playfield_engine_if.slave bus
);

  state_t     state_q, state_d;
  dir_t       cur_dir_q, cur_dir_d;
  dir_t       pend_dir_q, pend_dir_d;
  logic [5:0] seg_x_q [MAX_LEN];
  logic [5:0] seg_x_d [MAX_LEN];
  logic [4:0] seg_y_q [MAX_LEN];
  logic [4:0] seg_y_d [MAX_LEN];
  logic [5:0] length_q, length_d;
  logic [5:0] nxt_x_q, nxt_x_d;
  logic [4:0] nxt_y_q, nxt_y_d;
  logic       hit_q, hit_d;
  logic       eat_q, eat_d;
  logic       apple_eaten_q, apple_eaten_d;
  logic       game_over_q, game_over_d;
  cell_t      snake_q, snake_d;

  logic [5:0] q_col;
  logic [4:0] q_row;
  logic       q_in_range;
  logic       q_head, q_body;

  logic       chk_eat;
  logic       chk_grow;
  logic [5:0] chk_count;
  logic       self_head, self_body;

  assign q_col      = bus.x_pos[9:4];
  assign q_row      = bus.y_pos[8:4];
  assign q_in_range = (bus.x_pos < 10'(X_PIXELS)) && (bus.y_pos < 10'(Y_PIXELS));

  snake_cell_match #(.MAX_LEN(MAX_LEN)) u_query_match (
    .col      (q_col),
    .row      (q_row),
    .seg_x    (seg_x_q),
    .seg_y    (seg_y_q),
    .count    (length_q),
    .head_hit (q_head),
    .body_hit (q_body)
  );

  // The tail cell is vacated by the shift unless this move also grows the snake.
  assign chk_eat   = (nxt_x_q == bus.apple_x) && (nxt_y_q == bus.apple_y);
  assign chk_grow  = chk_eat && (length_q < 6'(MAX_LEN));
  assign chk_count = chk_grow ? length_q : (length_q - 6'd1);

  snake_cell_match #(.MAX_LEN(MAX_LEN)) u_self_match (
    .col      (nxt_x_q),
    .row      (nxt_y_q),
    .seg_x    (seg_x_q),
    .seg_y    (seg_y_q),
    .count    (chk_count),
    .head_hit (self_head),
    .body_hit (self_body)
  );

  always_comb begin
    state_d       = state_q;
    cur_dir_d     = cur_dir_q;
    pend_dir_d    = pend_dir_q;
    seg_x_d       = seg_x_q;
    seg_y_d       = seg_y_q;
    length_d      = length_q;
    nxt_x_d       = nxt_x_q;
    nxt_y_d       = nxt_y_q;
    hit_d         = hit_q;
    eat_d         = eat_q;
    apple_eaten_d = 1'b0;
    game_over_d   = game_over_q;

    if (!is_reverse(dir_t'(bus.dir_in), cur_dir_q)) begin
      pend_dir_d = dir_t'(bus.dir_in);
    end

    case (state_q)
      ST_PLAY: begin
        if (bus.step) begin
          cur_dir_d = pend_dir_q;
          nxt_x_d   = seg_x_q[0];
          nxt_y_d   = seg_y_q[0];
          case (pend_dir_q)
            DIR_UP:    nxt_y_d = seg_y_q[0] - 5'd1;
            DIR_DOWN:  nxt_y_d = seg_y_q[0] + 5'd1;
            DIR_LEFT:  nxt_x_d = seg_x_q[0] - 6'd1;
            default:   nxt_x_d = seg_x_q[0] + 6'd1;
          endcase
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        hit_d   = on_border(nxt_x_q, nxt_y_q) || self_head || self_body;
        eat_d   = chk_eat;
        state_d = ST_MOVE;
      end
      ST_MOVE: begin
        if (hit_q) begin
          game_over_d = 1'b1;
          state_d     = ST_OVER;
        end else begin
          for (int i = MAX_LEN - 1; i > 0; i--) begin
            seg_x_d[i] = seg_x_q[i-1];
            seg_y_d[i] = seg_y_q[i-1];
          end
          seg_x_d[0] = nxt_x_q;
          seg_y_d[0] = nxt_y_q;
          if (eat_q) begin
            apple_eaten_d = 1'b1;
            if (length_q < 6'(MAX_LEN)) begin
              length_d = length_q + 6'd1;
            end
          end
          state_d = ST_PLAY;
        end
      end
      default: state_d = ST_OVER;
    endcase
  end

  // Query sees the segment registers as they stand this cycle, i.e. pre-commit during MOVE.
  always_comb begin
    snake_d = CELL_NONE;
    if (q_in_range) begin
      if (on_border(q_col, q_row)) begin
        snake_d = CELL_WALL;
      end else if (q_head) begin
        snake_d = CELL_HEAD;
      end else if (q_body) begin
        snake_d = CELL_BODY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_PLAY;
      cur_dir_q  <= DIR_RIGHT;
      pend_dir_q <= DIR_RIGHT;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= (i < 3) ? 6'(START_X - i) : 6'd0;
        seg_y_q[i] <= (i < 3) ? 5'(START_Y) : 5'd0;
      end
      length_q      <= (MAX_LEN < 3) ? 6'(MAX_LEN) : 6'd3;
      nxt_x_q       <= 6'd0;
      nxt_y_q       <= 5'd0;
      hit_q         <= 1'b0;
      eat_q         <= 1'b0;
      apple_eaten_q <= 1'b0;
      game_over_q   <= 1'b0;
      snake_q       <= CELL_NONE;
    end else begin
      state_q       <= state_d;
      cur_dir_q     <= cur_dir_d;
      pend_dir_q    <= pend_dir_d;
      seg_x_q       <= seg_x_d;
      seg_y_q       <= seg_y_d;
      length_q      <= length_d;
      nxt_x_q       <= nxt_x_d;
      nxt_y_q       <= nxt_y_d;
      hit_q         <= hit_d;
      eat_q         <= eat_d;
      apple_eaten_q <= apple_eaten_d;
      game_over_q   <= game_over_d;
      snake_q       <= snake_d;
    end
  end

  assign bus.snake       = snake_q;
  assign bus.head_x      = seg_x_q[0];
  assign bus.head_y      = seg_y_q[0];
  assign bus.length      = length_q;
  assign bus.apple_eaten = apple_eaten_q;
  assign bus.game_over   = game_over_q;

endmodule

// File: tb/tb_snake_playfield_engine.sv
// Directed bench for snake_playfield_engine: reset, queries, moves, direction filter, growth, wall and self collision.
module tb_snake_playfield_engine;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   asserts = 0;
  int   fails = 0;

  snake_playfield_engine_if bus();

  snake_playfield_engine #(.MAX_LEN(16), .START_X(20), .START_Y(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b1;
    bus.step = 1'b0;
    bus.dir_in = 2'b11;
    bus.apple_x = 6'd1;
    bus.apple_y = 5'd1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Returns 1 ns after the commit edge (step edge + 2), when head/length/pulse are visible.
  task automatic do_step(input logic [1:0] d);
    bus.dir_in = d;
    @(posedge clk); #1;
    bus.step = 1'b1;
    @(posedge clk); #1;
    bus.step = 1'b0;
    @(posedge clk); @(posedge clk); #1;
  endtask

  task automatic query(input int x, input int y);
    bus.x_pos = 10'(x);
    bus.y_pos = 10'(y);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int qx [7] = '{320, 304, 288, 0, 700, 639, 100};
    int qy [7] = '{240, 240, 240, 0, 10, 479, 480};
    logic [1:0] qe [7] = '{2'b01, 2'b10, 2'b10, 2'b11, 2'b00, 2'b11, 2'b00};
    bus.x_pos = 10'd320; bus.y_pos = 10'd240;
    do_reset();
    asserts++; if (bus.head_x !== 6'd20 || bus.head_y !== 5'd15) begin fails++; $display("FAIL reset_head: got (%0d,%0d) expected (20,15)", bus.head_x, bus.head_y); end
    asserts++; if (bus.length !== 6'd3) begin fails++; $display("FAIL reset_length: got %0d expected 3", bus.length); end
    asserts++; if (bus.snake !== 2'b00) begin fails++; $display("FAIL reset_snake: got %b expected 00", bus.snake); end
    asserts++; if (bus.game_over !== 1'b0 || bus.apple_eaten !== 1'b0) begin fails++; $display("FAIL reset_flags: got go=%b ae=%b expected 0 0", bus.game_over, bus.apple_eaten); end
    for (int i = 0; i < 7; i++) begin
      query(qx[i], qy[i]);
      asserts++; if (bus.snake !== qe[i]) begin fails++; $display("FAIL reset_query(%0d,%0d): got %b expected %b", qx[i], qy[i], bus.snake, qe[i]); end
    end
  endtask

  task automatic test_move_and_dir();
    do_reset();
    do_step(2'b11);
    asserts++; if (bus.head_x !== 6'd21 || bus.head_y !== 5'd15) begin fails++; $display("FAIL move_right_head: got (%0d,%0d) expected (21,15)", bus.head_x, bus.head_y); end
    query(288, 240);
    asserts++; if (bus.snake !== 2'b00) begin fails++; $display("FAIL move_tail_vacated: got %b expected 00", bus.snake); end
    query(336, 240);
    asserts++; if (bus.snake !== 2'b01) begin fails++; $display("FAIL move_new_head_query: got %b expected 01", bus.snake); end
    do_step(2'b10);
    asserts++; if (bus.head_x !== 6'd22 || bus.head_y !== 5'd15) begin fails++; $display("FAIL reverse_ignored: got (%0d,%0d) expected (22,15)", bus.head_x, bus.head_y); end
    do_step(2'b00);
    asserts++; if (bus.head_x !== 6'd22 || bus.head_y !== 5'd14) begin fails++; $display("FAIL turn_up: got (%0d,%0d) expected (22,14)", bus.head_x, bus.head_y); end
  endtask

  task automatic test_step_while_busy();
    do_reset();
    bus.dir_in = 2'b11;
    @(posedge clk); #1;
    bus.step = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    bus.step = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    asserts++; if (bus.head_x !== 6'd21) begin fails++; $display("FAIL busy_step_ignored: got head_x %0d expected 21", bus.head_x); end
  endtask

  task automatic test_apple();
    do_reset();
    bus.apple_x = 6'd21; bus.apple_y = 5'd15;
    do_step(2'b11);
    asserts++; if (bus.apple_eaten !== 1'b1) begin fails++; $display("FAIL eat_pulse_high: got %b expected 1", bus.apple_eaten); end
    asserts++; if (bus.length !== 6'd4) begin fails++; $display("FAIL eat_length: got %0d expected 4", bus.length); end
    @(posedge clk); #1;
    asserts++; if (bus.apple_eaten !== 1'b0) begin fails++; $display("FAIL eat_pulse_width: got %b expected 0", bus.apple_eaten); end
    query(288, 240);
    asserts++; if (bus.snake !== 2'b10) begin fails++; $display("FAIL eat_tail_kept: got %b expected 10", bus.snake); end
    for (int k = 0; k < 12; k++) begin
      bus.apple_x = bus.head_x + 6'd1;
      do_step(2'b11);
    end
    asserts++; if (bus.length !== 6'd16 || bus.head_x !== 6'd33) begin fails++; $display("FAIL grow_to_max: got len %0d head %0d expected 16 33", bus.length, bus.head_x); end
    bus.apple_x = 6'd34;
    do_step(2'b11);
    asserts++; if (bus.apple_eaten !== 1'b1 || bus.length !== 6'd16) begin fails++; $display("FAIL eat_at_max: got ae %b len %0d expected 1 16", bus.apple_eaten, bus.length); end
    query(288, 240);
    asserts++; if (bus.snake !== 2'b00) begin fails++; $display("FAIL max_tail_dropped: got %b expected 00", bus.snake); end
    query(304, 240);
    asserts++; if (bus.snake !== 2'b10) begin fails++; $display("FAIL max_last_body: got %b expected 10", bus.snake); end
  endtask

  task automatic test_wall();
    do_reset();
    for (int k = 0; k < 18; k++) do_step(2'b11);
    asserts++; if (bus.head_x !== 6'd38 || bus.game_over !== 1'b0) begin fails++; $display("FAIL wall_approach: got head %0d go %b expected 38 0", bus.head_x, bus.game_over); end
    do_step(2'b11);
    asserts++; if (bus.game_over !== 1'b1 || bus.head_x !== 6'd38) begin fails++; $display("FAIL wall_hit: got go %b head %0d expected 1 38", bus.game_over, bus.head_x); end
    do_step(2'b00);
    asserts++; if (bus.head_x !== 6'd38 || bus.head_y !== 5'd15 || bus.length !== 6'd3) begin fails++; $display("FAIL over_step_noop: got (%0d,%0d) len %0d expected (38,15) 3", bus.head_x, bus.head_y, bus.length); end
    query(608, 240);
    asserts++; if (bus.snake !== 2'b01) begin fails++; $display("FAIL over_query_live: got %b expected 01", bus.snake); end
    do_reset();
    asserts++; if (bus.game_over !== 1'b0 || bus.head_x !== 6'd20) begin fails++; $display("FAIL over_reset_clears: got go %b head %0d expected 0 20", bus.game_over, bus.head_x); end
  endtask

  task automatic test_self_collision();
    do_reset();
    bus.apple_x = 6'd21; bus.apple_y = 5'd15;
    do_step(2'b11);
    bus.apple_x = 6'd22;
    do_step(2'b11);
    bus.apple_x = 6'd1; bus.apple_y = 5'd1;
    asserts++; if (bus.length !== 6'd5) begin fails++; $display("FAIL self_grow5: got %0d expected 5", bus.length); end
    do_step(2'b00);
    do_step(2'b10);
    do_step(2'b01);
    asserts++; if (bus.game_over !== 1'b1 || bus.head_x !== 6'd21 || bus.head_y !== 5'd14) begin fails++; $display("FAIL self_hit_body: got go %b (%0d,%0d) expected 1 (21,14)", bus.game_over, bus.head_x, bus.head_y); end
    // Length 4 chasing its own tail: safe unless the apple sits on the tail cell.
    for (int v = 0; v < 2; v++) begin
      do_reset();
      bus.apple_x = 6'd21; bus.apple_y = 5'd15;
      do_step(2'b11);
      bus.apple_x = (v == 0) ? 6'd1 : 6'd20;
      bus.apple_y = (v == 0) ? 5'd1 : 5'd15;
      do_step(2'b00);
      do_step(2'b10);
      do_step(2'b01);
      if (v == 0) begin
        asserts++; if (bus.game_over !== 1'b0 || bus.head_x !== 6'd20 || bus.head_y !== 5'd15) begin fails++; $display("FAIL tail_chase_safe: got go %b (%0d,%0d) expected 0 (20,15)", bus.game_over, bus.head_x, bus.head_y); end
      end else begin
        asserts++; if (bus.game_over !== 1'b1 || bus.head_y !== 5'd14) begin fails++; $display("FAIL tail_chase_grow_hit: got go %b row %0d expected 1 14", bus.game_over, bus.head_y); end
      end
    end
  endtask

  initial begin
    bus.step = 1'b0;
    bus.dir_in = 2'b11;
    bus.apple_x = 6'd1;
    bus.apple_y = 5'd1;
    bus.x_pos = 10'd0;
    bus.y_pos = 10'd0;
    test_reset();
    test_move_and_dir();
    test_step_while_busy();
    test_apple();
    test_wall();
    test_self_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
